// File: rtl/stutter_scheduler.sv
// Lockstep scheduler for a source/target program pair: drives per-copy stutter holds so that
// observable updates line up, flags unfair waits, and counts issued steps per copy.
module stutter_scheduler #(
   parameter int unsigned MAX_STUTTER = 3,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             halt_src,
   input  logic             halt_tgt,
   input  logic             obs_src,
   input  logic             obs_tgt,
   output logic             stutter_src,
   output logic             stutter_tgt,
   output logic [CNT_W-1:0] step_cnt_src,
   output logic [CNT_W-1:0] step_cnt_tgt,
   output logic             aligned,
   output logic             fair_viol,
   output logic             done
);

   localparam int unsigned WAIT_W = $clog2(MAX_STUTTER + 2);
   localparam logic [WAIT_W-1:0] WaitLimit = WAIT_W'(MAX_STUTTER + 1);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StRun     = 3'd1;
   localparam logic [2:0] StWaitSrc = 3'd2;
   localparam logic [2:0] StWaitTgt = 3'd3;
   localparam logic [2:0] StDone    = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
   logic              stutter_src_q, stutter_src_d;
   logic              stutter_tgt_q, stutter_tgt_d;
   logic [CNT_W-1:0]  cnt_src_q, cnt_src_d;
   logic [CNT_W-1:0]  cnt_tgt_q, cnt_tgt_d;
   logic              aligned_q, aligned_d;
   logic              fair_q, fair_d;
   logic              done_q, done_d;
   logic              in_wait;

   always_comb begin
      state_d   = state_q;
      aligned_d = 1'b0;
      fair_d    = fair_q;
      in_wait   = (state_q == StWaitSrc) || (state_q == StWaitTgt);
      wait_inc  = wait_q + 1'b1;

      case (state_q)
         StIdle: begin
            if (start) state_d = StRun;
         end
         StRun: begin
            if (halt_src && halt_tgt) begin
               state_d = StDone;
            end else if (obs_src && obs_tgt) begin
               aligned_d = 1'b1;
            end else if (obs_src && !halt_tgt) begin
               state_d = StWaitTgt;
            end else if (obs_tgt && !halt_src) begin
               state_d = StWaitSrc;
            end
         end
         StWaitSrc, StWaitTgt: begin
            if (halt_src && halt_tgt) begin
               state_d = StDone;
            end else if ((state_q == StWaitSrc) ? obs_src : obs_tgt) begin
               state_d   = StRun;
               aligned_d = 1'b1;
            end else if ((state_q == StWaitSrc) ? halt_src : halt_tgt) begin
               state_d = StRun;
            end else if (wait_inc == WaitLimit) begin
               state_d = StRun;
               fair_d  = 1'b1;
            end
         end
         StDone:  state_d = StDone;
         default: state_d = StIdle;
      endcase

      // Counter only survives while we remain in the same wait; any entry starts from zero.
      wait_d = (in_wait && state_d == state_q) ? wait_inc : '0;

      case (state_d)
         StRun: begin
            // Leaving IDLE releases both copies unconditionally.
            stutter_src_d = (state_q == StIdle) ? 1'b0 : halt_src;
            stutter_tgt_d = (state_q == StIdle) ? 1'b0 : halt_tgt;
         end
         StWaitSrc: begin
            stutter_src_d = 1'b0;
            stutter_tgt_d = 1'b1;
         end
         StWaitTgt: begin
            stutter_src_d = 1'b1;
            stutter_tgt_d = 1'b0;
         end
         default: begin
            stutter_src_d = 1'b1;
            stutter_tgt_d = 1'b1;
         end
      endcase

      done_d    = (state_d == StDone);
      cnt_src_d = (!stutter_src_q && cnt_src_q != '1) ? cnt_src_q + 1'b1 : cnt_src_q;
      cnt_tgt_d = (!stutter_tgt_q && cnt_tgt_q != '1) ? cnt_tgt_q + 1'b1 : cnt_tgt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         wait_q        <= '0;
         stutter_src_q <= 1'b1;
         stutter_tgt_q <= 1'b1;
         cnt_src_q     <= '0;
         cnt_tgt_q     <= '0;
         aligned_q     <= 1'b0;
         fair_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         stutter_src_q <= stutter_src_d;
         stutter_tgt_q <= stutter_tgt_d;
         cnt_src_q     <= cnt_src_d;
         cnt_tgt_q     <= cnt_tgt_d;
         aligned_q     <= aligned_d;
         fair_q        <= fair_d;
         done_q        <= done_d;
      end
   end

   assign stutter_src  = stutter_src_q;
   assign stutter_tgt  = stutter_tgt_q;
   assign step_cnt_src = cnt_src_q;
   assign step_cnt_tgt = cnt_tgt_q;
   assign aligned      = aligned_q;
   assign fair_viol    = fair_q;
   assign done         = done_q;

endmodule

// File: tb/tb_stutter_scheduler.sv
// Scenario bench for stutter_scheduler: each task queues expected outputs as it drives
// stimulus and pops them for comparison after the following clock edge.
module tb_stutter_scheduler;

   localparam logic [4:0] NONE  = 5'b00000;
   localparam logic [4:0] START = 5'b10000;
   localparam logic [4:0] HS    = 5'b01000;
   localparam logic [4:0] HT    = 5'b00100;
   localparam logic [4:0] OS    = 5'b00010;
   localparam logic [4:0] OT    = 5'b00001;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       halt_src = 1'b0, halt_tgt = 1'b0, obs_src = 1'b0, obs_tgt = 1'b0;
   logic       stutter_src, stutter_tgt, aligned, fair_viol, done;
   logic [3:0] step_cnt_src, step_cnt_tgt;

   logic [12:0] sb[$];
   logic [12:0] got, want;
   int          n_checks = 0;
   int          n_err = 0;

   stutter_scheduler #(.MAX_STUTTER(3), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .halt_src(halt_src), .halt_tgt(halt_tgt), .obs_src(obs_src), .obs_tgt(obs_tgt),
      .stutter_src(stutter_src), .stutter_tgt(stutter_tgt),
      .step_cnt_src(step_cnt_src), .step_cnt_tgt(step_cnt_tgt),
      .aligned(aligned), .fair_viol(fair_viol), .done(done)
   );

   always #5 clk = ~clk;

   // Packed view: {stutter_src, stutter_tgt, aligned, fair_viol, done, cnt_src, cnt_tgt}
   function automatic logic [12:0] outs();
      return {stutter_src, stutter_tgt, aligned, fair_viol, done, step_cnt_src, step_cnt_tgt};
   endfunction

   function automatic logic [12:0] mk(bit ss, bit st, bit al, bit fv, bit dn, int cs, int ct);
      return {ss, st, al, fv, dn, 4'(cs), 4'(ct)};
   endfunction

   task automatic apply(input logic [4:0] s, input logic [12:0] e);
      {start, halt_src, halt_tgt, obs_src, obs_tgt} = s;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0;
      start = 1'b1;
      sb.push_back(mk(1, 1, 0, 0, 0, 0, 0));
      #1;
      got = outs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
         n_err++; $display("FAIL reset_async: got %b want %b", got, want);
      end
      apply(START, mk(1, 1, 0, 0, 0, 0, 0));
      got = outs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
         n_err++; $display("FAIL reset_held: got %b want %b", got, want);
      end
      rst_n = 1'b1;
      apply(NONE, mk(1, 1, 0, 0, 0, 0, 0));
      got = outs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
         n_err++; $display("FAIL reset_idle: got %b want %b", got, want);
      end
   endtask

   task automatic test_run();
      for (int i = 0; i < 6; i++) begin
         apply((i == 0) ? START : NONE, mk(0, 0, 0, 0, 0, i, i));
         got = outs(); want = sb.pop_front(); n_checks++;
         if (got !== want) begin
            n_err++; $display("FAIL run[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_wait_align();
      logic [4:0]  s[4];
      logic [12:0] e[4];
      s = '{OS, NONE, OT, NONE};
      e = '{mk(1, 0, 0, 0, 0, 6, 6), mk(1, 0, 0, 0, 0, 6, 7),
            mk(0, 0, 1, 0, 0, 6, 8), mk(0, 0, 0, 0, 0, 7, 9)};
      for (int i = 0; i < 4; i++) begin
         apply(s[i], e[i]);
         got = outs(); want = sb.pop_front(); n_checks++;
         if (got !== want) begin
            n_err++; $display("FAIL wait_align[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_fairness();
      logic [4:0]  s[6];
      logic [12:0] e[6];
      s = '{OT, NONE, NONE, NONE, NONE, NONE};
      e = '{mk(0, 1, 0, 0, 0, 8, 10), mk(0, 1, 0, 0, 0, 9, 10), mk(0, 1, 0, 0, 0, 10, 10),
            mk(0, 1, 0, 0, 0, 11, 10), mk(0, 0, 0, 1, 0, 12, 10), mk(0, 0, 0, 1, 0, 13, 11)};
      for (int i = 0; i < 6; i++) begin
         apply(s[i], e[i]);
         got = outs(); want = sb.pop_front(); n_checks++;
         if (got !== want) begin
            n_err++; $display("FAIL fairness[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_simul_saturate();
      logic [4:0]  s[5];
      logic [12:0] e[5];
      s = '{OS | OT, NONE, NONE, NONE, NONE};
      e = '{mk(0, 0, 1, 1, 0, 14, 12), mk(0, 0, 0, 1, 0, 15, 13), mk(0, 0, 0, 1, 0, 15, 14),
            mk(0, 0, 0, 1, 0, 15, 15), mk(0, 0, 0, 1, 0, 15, 15)};
      for (int i = 0; i < 5; i++) begin
         apply(s[i], e[i]);
         got = outs(); want = sb.pop_front(); n_checks++;
         if (got !== want) begin
            n_err++; $display("FAIL simul_sat[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_halt_done();
      logic [4:0]  s[7];
      logic [12:0] e[7];
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      s = '{START, HS, HS | OT, HS, HS | HT, HS | HT | START, START};
      e = '{mk(0, 0, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 1, 1), mk(1, 0, 0, 0, 0, 1, 2),
            mk(1, 0, 0, 0, 0, 1, 3), mk(1, 1, 0, 0, 1, 1, 4), mk(1, 1, 0, 0, 1, 1, 4),
            mk(1, 1, 0, 0, 1, 1, 4)};
      for (int i = 0; i < 7; i++) begin
         apply(s[i], e[i]);
         got = outs(); want = sb.pop_front(); n_checks++;
         if (got !== want) begin
            n_err++; $display("FAIL halt_done[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [4:0]  s[5];
      logic [12:0] e[5];
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      s = '{START, OS, HT, OS, NONE};
      e = '{mk(0, 0, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 1, 1), mk(0, 1, 0, 0, 0, 1, 2),
            mk(1, 0, 0, 0, 0, 2, 2), mk(1, 0, 0, 0, 0, 2, 3)};
      for (int i = 0; i < 5; i++) begin
         apply(s[i], e[i]);
         got = outs(); want = sb.pop_front(); n_checks++;
         if (got !== want) begin
            n_err++; $display("FAIL mid_wait[%0d]: got %b want %b", i, got, want);
         end
      end
      rst_n = 1'b0;
      sb.push_back(mk(1, 1, 0, 0, 0, 0, 0));
      #1;
      got = outs(); want = sb.pop_front(); n_checks++;
      if (got !== want) begin
         n_err++; $display("FAIL mid_reset_async: got %b want %b", got, want);
      end
      #2;
      rst_n = 1'b1;
      s[0:2] = '{NONE, START, NONE};
      e[0:2] = '{mk(1, 1, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 1, 1)};
      for (int i = 0; i < 3; i++) begin
         apply(s[i], e[i]);
         got = outs(); want = sb.pop_front(); n_checks++;
         if (got !== want) begin
            n_err++; $display("FAIL post_reset[%0d]: got %b want %b", i, got, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_wait_align();
      test_fairness();
      test_simul_saturate();
      test_halt_done();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/stutter_scheduler.md
STUTTER_SCHEDULER -- requirements
Module: stutter_scheduler

Interface
REQ-001 Parameter MAX_STUTTER, default 3: maximum consecutive stutter cycles a non-halted copy may be held in an align wait.
REQ-002 Parameter CNT_W, default 4: width of the step counters.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a scheduling run from IDLE.
REQ-006 halt_src, halt_tgt  input  1 each  copy has reached its terminal computation step (level).
REQ-007 obs_src, obs_tgt  input  1 each  copy updated an observable output this cycle (pulse).
REQ-008 stutter_src, stutter_tgt  output  1 each  registered stutter_in drive to the source and target program models; 1 = hold.
REQ-009 step_cnt_src, step_cnt_tgt  output  CNT_W each  count of non-stutter cycles issued per copy.
REQ-010 aligned  output  1  one-cycle pulse when both copies have produced an observation at the same scheduling point.
REQ-011 fair_viol  output  1  sticky flag; a wait exceeded MAX_STUTTER.
REQ-012 done  output  1  high in DONE state.

Function
REQ-013 States IDLE, RUN, WAIT_SRC (source stepping, target held), WAIT_TGT (target stepping, source held), DONE; 3-bit encoding.
REQ-014 IDLE: both stutter outputs 1; start=1 -> RUN, both stutter outputs 0 in the next cycle.
REQ-015 RUN: each copy stutters iff its halt is high; otherwise both step in lockstep.
REQ-016 RUN, obs_src=1 and obs_tgt=0 with halt_tgt=0 -> WAIT_TGT; source stutters from the next cycle.
REQ-017 RUN, obs_tgt=1 and obs_src=0 with halt_src=0 -> WAIT_SRC, symmetric.
REQ-018 RUN, obs_src=1 and obs_tgt=1 in the same cycle -> stay in RUN; aligned=1 in the next cycle.
REQ-019 RUN, one copy observes while the other is halted -> stay in RUN; no wait, no aligned pulse.
REQ-020 WAIT_x: the copy named x steps; on obs_x=1 -> RUN and aligned=1 in the next cycle.
REQ-021 WAIT_x: halt_x=1 before obs_x -> RUN without an aligned pulse.
REQ-022 A wait-cycle counter resets on wait entry and increments each WAIT cycle; when it reaches MAX_STUTTER+1 without release, fair_viol sets (sticky until reset) and the FSM returns to RUN.
REQ-023 halt_src=1 and halt_tgt=1 in any non-IDLE state -> DONE next cycle; DONE has priority over wait/obs transitions.
REQ-024 DONE: both stutters 1, done=1; start ignored; exit only by reset.
REQ-025 start while not in IDLE is ignored.
REQ-026 step_cnt_x increments in every cycle in which stutter_x=0 is driven; saturates at 2^CNT_W-1 and does not wrap.
REQ-027 All outputs are registered; the response to any input appears one cycle later.

Reset
REQ-028 rst_n=0 immediately forces IDLE: stutter_src=stutter_tgt=1, step counters 0, aligned=0, fair_viol=0, done=0, wait counter 0.
REQ-029 Reset asserted mid-run (any state) aborts the run with the same values; the first posedge after release stays in IDLE until start.

Verification
REQ-030 Reset then start, halts 0, no obs for 5 cycles -> both stutters 0, step_cnt_src=step_cnt_tgt=5.
REQ-031 RUN, obs_src pulse, obs_tgt 2 cycles later -> stutter_src=1 for 2 cycles, aligned pulse once, step_cnt_src lags step_cnt_tgt by 2.
REQ-032 RUN, obs_tgt pulse, obs_src never, halt_src 0 -> after 4 WAIT_SRC cycles fair_viol=1, state RUN, fair_viol stays 1.
REQ-033 Simultaneous obs_src/obs_tgt -> no wait, aligned=1 next cycle, both stutters stay 0.
REQ-034 halt_src=1, then halt_tgt=1 3 cycles later -> stutter_src=1 from the cycle after halt_src, done=1 one cycle after halt_tgt, both stutters 1.
REQ-035 Run 20 steps with CNT_W=4 -> step counters saturate at 15; rst_n pulse in WAIT_TGT -> all outputs return to their reset values immediately.
